// File: rtl/aligner_axis_out_buffer_if.sv
// Bundles the aligner-side write port, the AXI4-Stream master port and the debug
// status of the aligner output buffer. The buffer uses the master modport; the
// aligner/sink side uses the slave modport.
interface aligner_axis_out_buffer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_tlast;
    logic                  in_wrt_en;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [CNT_WIDTH-1:0]  frame_words;
    logic [CNT_WIDTH-1:0]  frame_cnt;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   fill_level;

    modport master (
        input  in_data, in_valid, in_tlast, m_tready,
        output in_wrt_en, m_tdata, m_tvalid, m_tlast,
        output frame_words, frame_cnt, overflow, fill_level
    );

    modport slave (
        output in_data, in_valid, in_tlast, m_tready,
        input  in_wrt_en, m_tdata, m_tvalid, m_tlast,
        input  frame_words, frame_cnt, overflow, fill_level
    );
endinterface

// File: rtl/aligner_axis_out_buffer.sv
// Output buffer behind the 256-bit aligner: a FWFT FIFO presented as an AXI4-Stream
// master, with registered almost-full write enable back to the aligner and frame debug counters.
module aligner_axis_out_buffer #(
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_MARGIN = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    aligner_axis_out_buffer_if.master  bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   MARGIN_C = (ADDR_WIDTH+1)'(AFULL_MARGIN);
    localparam logic [ADDR_WIDTH:0]   CNT1     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR1     = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  WORD1    = CNT_WIDTH'(1);

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d, avail;
    logic                  wrt_en_q, wrt_en_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  frame_words_q, frame_words_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH:0]   head;
    logic                  push, pop, full, push_acc;

    always_comb begin
        push     = bus.in_valid & wrt_en_q;
        pop      = tvalid_q & bus.m_tready;
        full     = (count_q == DEPTH_C);
        push_acc = push & (~full | pop);

        wr_ptr_d = push_acc ? wr_ptr_q + PTR1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR1 : rd_ptr_q;

        count_d = count_q;
        if (push_acc && !pop)
            count_d = count_q + CNT1;
        else if (!push_acc && pop)
            count_d = count_q - CNT1;

        // Words pushed on this edge are excluded so they appear one cycle later,
        // which also guarantees the new head is already resident in mem_q.
        avail    = pop ? count_q - CNT1 : count_q;
        head     = mem_q[rd_ptr_d];
        tvalid_d = (avail != '0);
        tdata_d  = tvalid_d ? head[DATA_WIDTH-1:0] : '0;
        tlast_d  = tvalid_d & head[DATA_WIDTH];

        wrt_en_d   = ((DEPTH_C - count_d) >= MARGIN_C);
        overflow_d = overflow_q | (push & full & ~pop);

        word_cnt_d    = word_cnt_q;
        frame_words_d = frame_words_q;
        frame_cnt_d   = frame_cnt_q;
        if (pop) begin
            if (tlast_q) begin
                frame_words_d = word_cnt_q + WORD1;
                word_cnt_d    = '0;
                frame_cnt_d   = frame_cnt_q + WORD1;
            end else begin
                word_cnt_d = word_cnt_q + WORD1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc)
            mem_q[wr_ptr_q] <= {bus.in_tlast, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wrt_en_q      <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            overflow_q    <= 1'b0;
            word_cnt_q    <= '0;
            frame_words_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wrt_en_q      <= wrt_en_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
            overflow_q    <= overflow_d;
            word_cnt_q    <= word_cnt_d;
            frame_words_q <= frame_words_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.in_wrt_en   = wrt_en_q;
    assign bus.m_tvalid    = tvalid_q;
    assign bus.m_tdata     = tdata_q;
    assign bus.m_tlast     = tlast_q;
    assign bus.frame_words = frame_words_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.overflow    = overflow_q;
    assign bus.fill_level  = count_q;
endmodule

// File: tb/tb_aligner_axis_out_buffer.sv
// Directed bench for aligner_axis_out_buffer; a second instance built with no
// almost-full margin lets the aligner overrun the FIFO to exercise overflow.
module tb_aligner_axis_out_buffer;
    localparam int DW = 256;
    localparam int AW = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aligner_axis_out_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bif ();
    aligner_axis_out_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bif2 ();

    aligner_axis_out_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
                              .AFULL_MARGIN(4), .CNT_WIDTH(CW))
        dut (.clk(clk), .reset(reset), .bus(bif));

    aligner_axis_out_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
                              .AFULL_MARGIN(0), .CNT_WIDTH(CW))
        dut2 (.clk(clk), .reset(reset), .bus(bif2));

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] seq = 32'h100;
    logic        last_push;
    logic [DW:0] exp_q[$];
    logic [DW:0] got_q[$];

    // Advance one edge, logging words accepted by / popped from the main instance.
    task automatic step();
        logic pu, po;
        logic [DW:0] pw, ow;
        pu = !reset && bif.in_valid && bif.in_wrt_en;
        po = !reset && bif.m_tvalid && bif.m_tready;
        pw = {bif.in_tlast, bif.in_data};
        ow = {bif.m_tlast, bif.m_tdata};
        @(posedge clk);
        #1;
        if (pu) exp_q.push_back(pw);
        if (po) got_q.push_back(ow);
        last_push = pu;
    endtask

    task automatic drain();
        int k;
        bif.in_valid = 1'b0;
        bif.in_tlast = 1'b0;
        bif.m_tready = 1'b1;
        k = 0;
        while ((bif.m_tvalid || bif.fill_level != 0) && k < 60) begin
            step();
            k++;
        end
        n_assert++;
        if (bif.fill_level !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_timeout: fill_level=%0d required 0", bif.fill_level);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_assert++;
        if ({bif.in_wrt_en, bif.m_tvalid, bif.m_tlast, bif.overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: wrt_en/tvalid/tlast/ovf=%b required 0000",
                     {bif.in_wrt_en, bif.m_tvalid, bif.m_tlast, bif.overflow});
        end
        n_assert++;
        if (bif.m_tdata !== '0 || bif.fill_level !== 5'd0 || bif.frame_words !== 16'd0
            || bif.frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: fill=%0d fw=%0d fc=%0d required 0",
                     bif.fill_level, bif.frame_words, bif.frame_cnt);
        end
        reset = 1'b0;
        step();
        n_assert++;
        if (bif.in_wrt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wrt_en_rise: got %b required 1", bif.in_wrt_en);
        end
    endtask

    task automatic test_basic_frame();
        bif.m_tready = 1'b1;
        bif.in_valid = 1'b1; bif.in_tlast = 1'b0; bif.in_data = {8{seq}};
        step(); seq++;
        n_assert++;
        if (bif.m_tvalid !== 1'b0 || bif.fill_level !== 5'd1) begin
            n_fail++;
            $display("FAIL basic_latency: tvalid=%b fill=%0d required 0 and 1",
                     bif.m_tvalid, bif.fill_level);
        end
        bif.in_data = {8{seq}};
        step(); seq++;
        n_assert++;
        if (bif.m_tvalid !== 1'b1 || bif.m_tdata !== {8{32'h100}} || bif.m_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_beat1: tvalid=%b tlast=%b data=%0h", bif.m_tvalid,
                     bif.m_tlast, bif.m_tdata[31:0]);
        end
        bif.in_data = {8{seq}}; bif.in_tlast = 1'b1;
        step(); seq++;
        n_assert++;
        if (bif.m_tvalid !== 1'b1 || bif.m_tdata !== {8{32'h101}} || bif.m_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_beat2: tvalid=%b tlast=%b data=%0h", bif.m_tvalid,
                     bif.m_tlast, bif.m_tdata[31:0]);
        end
        bif.in_valid = 1'b0; bif.in_tlast = 1'b0;
        step();
        n_assert++;
        if (bif.m_tvalid !== 1'b1 || bif.m_tdata !== {8{32'h102}} || bif.m_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_beat3: tvalid=%b tlast=%b data=%0h", bif.m_tvalid,
                     bif.m_tlast, bif.m_tdata[31:0]);
        end
        step();
        n_assert++;
        if (bif.m_tvalid !== 1'b0 || bif.frame_words !== 16'd3 || bif.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_counters: tvalid=%b fw=%0d fc=%0d required 0 3 1",
                     bif.m_tvalid, bif.frame_words, bif.frame_cnt);
        end
        n_assert++;
        if (got_q.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats required 3", got_q.size());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        int max_fill = 0;
        bif.m_tready = 1'b0;
        bif.in_valid = 1'b1; bif.in_tlast = 1'b0; bif.in_data = {8{seq}};
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_push) begin seq++; bif.in_data = {8{seq}}; end
            if (int'(bif.fill_level) > max_fill) max_fill = int'(bif.fill_level);
        end
        n_assert++;
        if (max_fill !== 13 || bif.fill_level !== 5'd13) begin
            n_fail++;
            $display("FAIL bp_fill: max=%0d now=%0d required 13", max_fill, bif.fill_level);
        end
        n_assert++;
        if (bif.in_wrt_en !== 1'b0 || bif.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_wrt_en: wrt_en=%b ovf=%b required 0 0", bif.in_wrt_en, bif.overflow);
        end
        bif.m_tready = 1'b1;
        step();
        bif.m_tready = 1'b0;
        n_assert++;
        if (bif.fill_level !== 5'd12 || bif.in_wrt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_one_pop: fill=%0d wrt_en=%b required 12 1",
                     bif.fill_level, bif.in_wrt_en);
        end
        step();
        if (last_push) begin seq++; bif.in_data = {8{seq}}; end
        n_assert++;
        if (bif.fill_level !== 5'd13 || bif.in_wrt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_refill: fill=%0d wrt_en=%b required 13 0",
                     bif.fill_level, bif.in_wrt_en);
        end
        drain();
        n_assert++;
        if (exp_q.size() !== 14 || got_q.size() !== 14) begin
            n_fail++;
            $display("FAIL bp_count: pushed=%0d popped=%0d required 14",
                     exp_q.size(), got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i] || exp_q[i][31:0] !== 32'h103 + 32'(i)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %0h required %0h", i,
                         got_q[i][31:0], 32'h103 + 32'(i));
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        bif2.m_tready = 1'b0;
        bif2.in_valid = 1'b1; bif2.in_tlast = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bif2.in_data = {8{32'(i + 1)}};
            step();
        end
        n_assert++;
        if (bif2.fill_level !== 5'd16 || bif2.overflow !== 1'b0 || bif2.in_wrt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: fill=%0d ovf=%b wrt_en=%b required 16 0 1",
                     bif2.fill_level, bif2.overflow, bif2.in_wrt_en);
        end
        bif2.in_data = {8{32'd17}};
        step();
        bif2.in_valid = 1'b0;
        n_assert++;
        if (bif2.fill_level !== 5'd16 || bif2.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: fill=%0d ovf=%b required 16 1", bif2.fill_level, bif2.overflow);
        end
        n_assert++;
        if (bif2.m_tdata !== {8{32'd1}}) begin
            n_fail++;
            $display("FAIL ovf_head: got %0h required 1", bif2.m_tdata[31:0]);
        end
        bif2.m_tready = 1'b1;
        step();
        step();
        bif2.m_tready = 1'b0;
        n_assert++;
        if (bif2.fill_level !== 5'd14 || bif2.overflow !== 1'b1 || bif2.m_tdata !== {8{32'd3}}) begin
            n_fail++;
            $display("FAIL ovf_sticky: fill=%0d ovf=%b head=%0h required 14 1 3",
                     bif2.fill_level, bif2.overflow, bif2.m_tdata[31:0]);
        end
        n_assert++;
        if (bif.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_main_clean: got %b required 0", bif.overflow);
        end
    endtask

    task automatic test_back_to_back();
        bif.m_tready = 1'b0;
        bif.in_valid = 1'b1; bif.in_tlast = 1'b0; bif.in_data = {8{seq}};
        step(); if (last_push) begin seq++; bif.in_data = {8{seq}}; end
        step(); if (last_push) begin seq++; bif.in_data = {8{seq}}; end
        bif.m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bif.in_tlast = (i == 39);
            step();
            if (last_push) begin seq++; bif.in_data = {8{seq}}; end
            n_assert++;
            if (bif.fill_level !== 5'd2) begin
                n_fail++;
                $display("FAIL b2b_fill[%0d]: got %0d required 2", i, bif.fill_level);
            end
        end
        drain();
        n_assert++;
        if (exp_q.size() !== 42 || got_q.size() !== 42) begin
            n_fail++;
            $display("FAIL b2b_count: pushed=%0d popped=%0d required 42",
                     exp_q.size(), got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i] || exp_q[i][31:0] !== 32'h111 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %0h required %0h", i,
                         got_q[i][31:0], 32'h111 + 32'(i));
            end
        end
        n_assert++;
        if (bif.frame_words !== 16'd56 || bif.frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_counters: fw=%0d fc=%0d required 56 2",
                     bif.frame_words, bif.frame_cnt);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        bif.m_tready = 1'b0;
        bif.in_valid = 1'b1; bif.in_tlast = 1'b0; bif.in_data = {8{seq}};
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_push) begin seq++; bif.in_data = {8{seq}}; end
        end
        bif.in_valid = 1'b0;
        reset = 1'b1;
        step();
        n_assert++;
        if (bif.m_tvalid !== 1'b0 || bif.fill_level !== 5'd0 || bif.frame_cnt !== 16'd0
            || bif.frame_words !== 16'd0 || bif.in_wrt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: tvalid=%b fill=%0d fc=%0d fw=%0d wrt_en=%b required all 0",
                     bif.m_tvalid, bif.fill_level, bif.frame_cnt, bif.frame_words, bif.in_wrt_en);
        end
        reset = 1'b0;
        step();
        n_assert++;
        if (bif.m_tvalid !== 1'b0 || bif.in_wrt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: tvalid=%b wrt_en=%b required 0 1", bif.m_tvalid, bif.in_wrt_en);
        end
        exp_q.delete(); got_q.delete();
        bif.m_tready = 1'b1;
        bif.in_valid = 1'b1; bif.in_tlast = 1'b0; bif.in_data = {8{seq}};
        step(); seq++;
        bif.in_data = {8{seq}}; bif.in_tlast = 1'b1;
        step(); seq++;
        drain();
        n_assert++;
        if (bif.frame_words !== 16'd2 || bif.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_new_frame: fw=%0d fc=%0d required 2 1", bif.frame_words, bif.frame_cnt);
        end
        n_assert++;
        if (got_q.size() !== 2 || exp_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL rst_new_data: popped=%0d pushed=%0d or data differs",
                     got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        bif.in_data = '0;  bif.in_valid = 1'b0;  bif.in_tlast = 1'b0;  bif.m_tready = 1'b0;
        bif2.in_data = '0; bif2.in_valid = 1'b0; bif2.in_tlast = 1'b0; bif2.m_tready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
